axi_store_engine: RTL and testbench
===================================

Name: axi_store_engine

Overview:
Parametrised successor to the LSU store buffer. It accepts one store command describing N chunks, and each chunk becomes one AXI INCR write burst. For every chunk the block reads SRAM lines, slices each line into AXI beats, drives AW/W, and collects B. Chunks that receive SLVERR/DECERR are recorded and resent in later passes, up to a retry limit, before the block reports completion to the LSU controller.

Parameters:
ID_WIDTH, 8, AXI awid width
ADDR_WIDTH, 10, AXI awaddr width
AXI_DATA_WIDTH, 64, W beat width; power of 2, at least 8
SRAM_DATA_WIDTH, 128, SRAM line width; integer multiple RATIO of AXI_DATA_WIDTH
SRAM_ADDR_WIDTH, 8, SRAM line address width
MAX_CHUNKS, 16, maximum chunks per command; also the width of the fail bitmap
MAX_RETRY, 3, maximum resend passes after the first pass

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_vld  in  1  command valid
cmd_rdy  out  1  high only in IDLE
cmd_awid  in  ID_WIDTH  burst id, same for all chunks
cmd_awaddr  in  ADDR_WIDTH  byte address of chunk 0
cmd_awlen  in  8  beats per chunk minus 1
cmd_chunk_num  in  $clog2(MAX_CHUNKS)  chunks minus 1
cmd_sram_addr  in  SRAM_ADDR_WIDTH  SRAM line holding chunk 0
sram_ren  out  1  SRAM read strobe
sram_addr  out  SRAM_ADDR_WIDTH  SRAM line address
sram_rdata  in  SRAM_DATA_WIDTH  read data, valid exactly 1 cycle after sram_ren
awvld/awrdy  out/in  1  AW handshake
awid, awaddr, awlen  out  ID_WIDTH, ADDR_WIDTH, 8  AW payload
awsize, awburst  out  3, 2  fixed: log2(AXI_DATA_WIDTH/8), 2'b01
wvld/wrdy  out/in  1  W handshake
wdata, wstrb, wlast  out  AXI_DATA_WIDTH, AXI_DATA_WIDTH/8, 1  W payload
bvld  in  1  B valid
bresp  in  2  B response
brdy  out  1  B ready
done  out  1  one-cycle completion pulse
done_err  out  1  failures remain; valid with done
done_fail_map  out  MAX_CHUNKS  failed chunk bitmap; held until next command accepted

Behaviour:
- Reset: all outputs 0 except cmd_rdy=1. State = IDLE; fail bitmap, retry count and line register cleared. Reset mid-burst aborts the transfer; no completion is reported.
- Command capture: on cmd_vld&cmd_rdy all cmd fields are registered. Active map = bits 0..cmd_chunk_num set. Pass = 0. Go to AW with chunk index k = lowest set bit of the active map.
- Chunk k addresses:
  - awaddr = cmd_awaddr + k*((awlen+1)*AXI_DATA_WIDTH/8), truncated to ADDR_WIDTH (wraps).
  - SRAM base = cmd_sram_addr + k*ceil((awlen+1)/RATIO), wraps modulo 2^SRAM_ADDR_WIDTH.
  - Every chunk starts on a fresh line; unused beats of a chunk's last line are discarded.
- States:
  - IDLE -> AW on command accept.
  - AW: awvld=1 with payload stable until awrdy. Then RD.
  - RD: sram_ren=1 for one cycle, sram_addr = current line. Next state RDW.
  - RDW: capture sram_rdata into the line register, beat index b=0. Next state W.
  - W: wvld=1, wdata = line[b*AXI_DATA_WIDTH +: AXI_DATA_WIDTH], wstrb all ones. Payload held while wrdy=0. On handshake:
    - beat was awlen -> wlast was 1, go to B;
    - else b reached RATIO-1 -> line+1, go to RD;
    - else b+1, stay in W.
  - B: brdy=1. On bvld:
    - bresp!=0 sets fail bit k, bresp==0 clears it.
    - Next set bit of the active map above k -> AW.
    - Otherwise the pass ends: if the fail map is nonzero and pass<MAX_RETRY, then active map = fail map, pass+1, go to AW at its lowest bit; else go to DONE.
  - DONE: done=1 for one cycle, done_err=|fail map, done_fail_map=fail map. Next state IDLE.
- Only one burst is outstanding at a time. W never starts before AW has been accepted.
- awvld and wvld never deassert before their handshake.
- Boundary cases:
  - cmd_chunk_num=0 gives a single chunk.
  - awlen=0 gives a single-beat burst with wlast=1.
  - cmd_chunk_num values above MAX_CHUNKS-1 are illegal and the bench must never drive them.
  - Minimum latency from cmd accept to first wvld is 4 cycles when awrdy=1.

Optional Feature:
STORE_ENG_TAIL_STRB_EN:
- Defined: adds input cmd_tail_bytes, width $clog2(AXI_DATA_WIDTH/8), captured with the command. The last beat of every chunk drives wstrb=(1<<cmd_tail_bytes)-1 when cmd_tail_bytes!=0; all other beats stay all ones.
- Undefined: the port is absent and wstrb is always all ones.

Test Plan:
1. cmd_awaddr=0x040, awlen=3, chunk_num=1, sram_addr=0x10, awrdy=wrdy=1, bresp=0 -> AW addrs 0x040 and 0x060; SRAM reads 0x10,0x11,0x12,0x13; 8 beats, wlast on beats 4 and 8; done=1, done_err=0.
2. Same command with chunk 1 returning SLVERR once -> pass 1 resends only awaddr 0x060 from SRAM 0x12; done_err=0, done_fail_map=0.
3. Chunk 0 always DECERR, MAX_RETRY=3 -> exactly 4 AW for chunk 0 in total; done_err=1, done_fail_map=0x0001.
4. awlen=2, RATIO=2, random wrdy/awrdy stalls -> payload stable during stalls; beat 3 taken from the low half of line 2; upper half discarded.
5. rst_n low during W of beat 1 -> all outputs 0 and cmd_rdy=1 asynchronously; a new command then completes normally.
6. With STORE_ENG_TAIL_STRB_EN and cmd_tail_bytes=3 -> last beat of each chunk has wstrb=0x07; all other beats 0xFF.

Source files
------------

// File: rtl/axi_store_engine.sv
// axi_store_engine: turns one store command into per-chunk AXI INCR write bursts fed from SRAM lines,
// resending failed chunks for up to MAX_RETRY passes. Macro STORE_ENG_TAIL_STRB_EN adds tail-beat strobes.
module axi_store_engine #(
    parameter int ID_WIDTH        = 8,
    parameter int ADDR_WIDTH      = 10,
    parameter int AXI_DATA_WIDTH  = 64,
    parameter int SRAM_DATA_WIDTH = 128,
    parameter int SRAM_ADDR_WIDTH = 8,
    parameter int MAX_CHUNKS      = 16,
    parameter int MAX_RETRY       = 3
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cmd_vld,
    output logic                            cmd_rdy,
    input  logic [ID_WIDTH-1:0]             cmd_awid,
    input  logic [ADDR_WIDTH-1:0]           cmd_awaddr,
    input  logic [7:0]                      cmd_awlen,
    input  logic [$clog2(MAX_CHUNKS)-1:0]   cmd_chunk_num,
    input  logic [SRAM_ADDR_WIDTH-1:0]      cmd_sram_addr,
`ifdef STORE_ENG_TAIL_STRB_EN
    input  logic [$clog2(AXI_DATA_WIDTH/8)-1:0] cmd_tail_bytes,
`endif
    output logic                            sram_ren,
    output logic [SRAM_ADDR_WIDTH-1:0]      sram_addr,
    input  logic [SRAM_DATA_WIDTH-1:0]      sram_rdata,
    output logic                            awvld,
    input  logic                            awrdy,
    output logic [ID_WIDTH-1:0]             awid,
    output logic [ADDR_WIDTH-1:0]           awaddr,
    output logic [7:0]                      awlen,
    output logic [2:0]                      awsize,
    output logic [1:0]                      awburst,
    output logic                            wvld,
    input  logic                            wrdy,
    output logic [AXI_DATA_WIDTH-1:0]       wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]     wstrb,
    output logic                            wlast,
    input  logic                            bvld,
    input  logic [1:0]                      bresp,
    output logic                            brdy,
    output logic                            done,
    output logic                            done_err,
    output logic [MAX_CHUNKS-1:0]           done_fail_map
);
    localparam int RATIO  = SRAM_DATA_WIDTH / AXI_DATA_WIDTH;
    localparam int STRB_W = AXI_DATA_WIDTH / 8;
    localparam int CW     = $clog2(MAX_CHUNKS);
    localparam int SW     = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int PW     = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int TW     = $clog2(STRB_W);
    localparam logic [2:0]    AWSIZE_C   = 3'($clog2(STRB_W));
    localparam logic [SW-1:0] SUB_LAST_C = SW'(RATIO - 1);
    localparam logic [PW-1:0] RETRY_C    = PW'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_AW = 3'd1, S_RD = 3'd2, S_RDW = 3'd3, S_W = 3'd4, S_B = 3'd5, S_DONE = 3'd6
    } state_t;

    state_t                       state_q, state_d;
    logic [ID_WIDTH-1:0]          awid_q, awid_d;
    logic [ADDR_WIDTH-1:0]        base_awaddr_q, base_awaddr_d, chunk_awaddr_q, chunk_awaddr_d;
    logic [7:0]                   awlen_q, awlen_d, beat_q, beat_d;
    logic [SRAM_ADDR_WIDTH-1:0]   base_sram_q, base_sram_d, line_addr_q, line_addr_d;
    logic [MAX_CHUNKS-1:0]        active_q, active_d, fail_q, fail_d, done_map_q, done_map_d;
    logic [PW-1:0]                pass_q, pass_d;
    logic [CW-1:0]                k_q, k_d;
    logic [SRAM_DATA_WIDTH-1:0]   line_q, line_d;
    logic [SW-1:0]                sub_q, sub_d;
    logic [TW-1:0]                tail_q, tail_d;
    logic [MAX_CHUNKS-1:0]        mask_s, fail_upd_s;
    logic [CW:0]                  nxt_s, restart_s;
    logic [CW-1:0]                ld_k_s;
    logic                         last_beat_s;
    logic [STRB_W-1:0]            strb_s;

    // Lowest set bit of map at or above start; MSB flags that one was found.
    function automatic logic [CW:0] first_set(input logic [MAX_CHUNKS-1:0] map, input logic [CW:0] start);
        logic [CW:0] res;
        res = '0;
        for (int i = MAX_CHUNKS - 1; i >= 0; i--) begin
            if (map[i] && (i >= int'(start))) begin
                res = {1'b1, CW'(i)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] chunk_awaddr(input logic [ADDR_WIDTH-1:0] base,
                                                           input logic [7:0] len, input logic [CW-1:0] k);
        return ADDR_WIDTH'(32'(base) + 32'(k) * (32'(len) + 32'd1) * 32'(STRB_W));
    endfunction

    // Each chunk begins on a fresh line, so it occupies ceil((len+1)/RATIO) lines.
    function automatic logic [SRAM_ADDR_WIDTH-1:0] chunk_line(input logic [SRAM_ADDR_WIDTH-1:0] base,
                                                             input logic [7:0] len, input logic [CW-1:0] k);
        return SRAM_ADDR_WIDTH'(32'(base) + 32'(k) * ((32'(len) + 32'(RATIO)) / 32'(RATIO)));
    endfunction

    // Active-chunk mask for a new command plus the pass-advance lookups.
    always_comb begin
        mask_s = '0;
        for (int i = 0; i < MAX_CHUNKS; i++) begin
            mask_s[i] = (i <= int'(cmd_chunk_num));
        end
        fail_upd_s        = fail_q;
        fail_upd_s[k_q]   = (bresp != 2'b00);
        nxt_s             = first_set(active_q, (CW+1)'(k_q) + (CW+1)'(1));
        restart_s         = first_set(fail_upd_s, (CW+1)'(0));
        ld_k_s            = nxt_s[CW] ? nxt_s[CW-1:0] : restart_s[CW-1:0];
        last_beat_s       = (beat_q == awlen_q);
    end

    // State register and datapath flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            awid_q         <= '0;
            base_awaddr_q  <= '0;
            chunk_awaddr_q <= '0;
            awlen_q        <= '0;
            beat_q         <= '0;
            base_sram_q    <= '0;
            line_addr_q    <= '0;
            active_q       <= '0;
            fail_q         <= '0;
            done_map_q     <= '0;
            pass_q         <= '0;
            k_q            <= '0;
            line_q         <= '0;
            sub_q          <= '0;
            tail_q         <= '0;
        end else begin
            state_q        <= state_d;
            awid_q         <= awid_d;
            base_awaddr_q  <= base_awaddr_d;
            chunk_awaddr_q <= chunk_awaddr_d;
            awlen_q        <= awlen_d;
            beat_q         <= beat_d;
            base_sram_q    <= base_sram_d;
            line_addr_q    <= line_addr_d;
            active_q       <= active_d;
            fail_q         <= fail_d;
            done_map_q     <= done_map_d;
            pass_q         <= pass_d;
            k_q            <= k_d;
            line_q         <= line_d;
            sub_q          <= sub_d;
            tail_q         <= tail_d;
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_d        = state_q;
        awid_d         = awid_q;
        base_awaddr_d  = base_awaddr_q;
        chunk_awaddr_d = chunk_awaddr_q;
        awlen_d        = awlen_q;
        beat_d         = beat_q;
        base_sram_d    = base_sram_q;
        line_addr_d    = line_addr_q;
        active_d       = active_q;
        fail_d         = fail_q;
        done_map_d     = done_map_q;
        pass_d         = pass_q;
        k_d            = k_q;
        line_d         = line_q;
        sub_d          = sub_q;
        tail_d         = tail_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_vld) begin
                    awid_d         = cmd_awid;
                    base_awaddr_d  = cmd_awaddr;
                    chunk_awaddr_d = cmd_awaddr;
                    awlen_d        = cmd_awlen;
                    base_sram_d    = cmd_sram_addr;
                    line_addr_d    = cmd_sram_addr;
                    active_d       = mask_s;
                    fail_d         = '0;
                    done_map_d     = '0;
                    pass_d         = '0;
                    k_d            = '0;
`ifdef STORE_ENG_TAIL_STRB_EN
                    tail_d         = cmd_tail_bytes;
`else
                    tail_d         = '0;
`endif
                    state_d        = S_AW;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_AW: begin
                beat_d  = 8'd0;
                state_d = awrdy ? S_RD : S_AW;
            end
            S_RD:  state_d = S_RDW;
            S_RDW: begin
                line_d  = sram_rdata;
                sub_d   = SW'(0);
                state_d = S_W;
            end
            S_W: begin
                if (!wrdy) begin
                    state_d = S_W;
                end else if (last_beat_s) begin
                    state_d = S_B;
                end else if (sub_q == SUB_LAST_C) begin
                    beat_d      = beat_q + 8'd1;
                    line_addr_d = line_addr_q + SRAM_ADDR_WIDTH'(1);
                    state_d     = S_RD;
                end else begin
                    beat_d  = beat_q + 8'd1;
                    sub_d   = sub_q + SW'(1);
                    state_d = S_W;
                end
            end
            S_B: begin
                if (!bvld) begin
                    state_d = S_B;
                end else if (nxt_s[CW] || ((|fail_upd_s) && (pass_q < RETRY_C))) begin
                    fail_d         = fail_upd_s;
                    k_d            = ld_k_s;
                    chunk_awaddr_d = chunk_awaddr(base_awaddr_q, awlen_q, ld_k_s);
                    line_addr_d    = chunk_line(base_sram_q, awlen_q, ld_k_s);
                    if (nxt_s[CW]) begin
                        active_d = active_q;
                    end else begin
                        active_d = fail_upd_s;
                        pass_d   = pass_q + PW'(1);
                    end
                    state_d = S_AW;
                end else begin
                    fail_d     = fail_upd_s;
                    done_map_d = fail_upd_s;
                    state_d    = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Tail-beat strobe selection.
    always_comb begin
        strb_s = '1;
        if (last_beat_s && (tail_q != '0)) begin
            for (int i = 0; i < STRB_W; i++) begin
                strb_s[i] = (i < int'(tail_q));
            end
        end else begin
            strb_s = '1;
        end
    end

    // Outputs decoded from the registered state and datapath.
    always_comb begin
        cmd_rdy       = (state_q == S_IDLE);
        awvld         = (state_q == S_AW);
        awid          = awid_q;
        awaddr        = chunk_awaddr_q;
        awlen         = awlen_q;
        awsize        = AWSIZE_C;
        awburst       = 2'b01;
        sram_ren      = (state_q == S_RD);
        sram_addr     = (state_q == S_RD) ? line_addr_q : '0;
        wvld          = (state_q == S_W);
        wdata         = '0;
        wstrb         = '0;
        wlast         = 1'b0;
        brdy          = (state_q == S_B);
        done          = (state_q == S_DONE);
        done_err      = (state_q == S_DONE) && (|fail_q);
        done_fail_map = done_map_q;
        if (state_q == S_W) begin
            wdata = line_q[int'(sub_q) * AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
            wstrb = strb_s;
            wlast = last_beat_s;
        end else begin
            wdata = '0;
        end
    end
endmodule

// File: tb/tb_axi_store_engine.sv
// Directed bench for axi_store_engine: a vector table of commands driven through an AXI/SRAM responder,
// plus a mid-burst reset sequence.
module tb_axi_store_engine;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_vld, cmd_rdy;
    logic [7:0]   cmd_awid;
    logic [9:0]   cmd_awaddr;
    logic [7:0]   cmd_awlen;
    logic [3:0]   cmd_chunk_num;
    logic [7:0]   cmd_sram_addr;
    logic         sram_ren;
    logic [7:0]   sram_addr;
    logic [127:0] sram_rdata;
    logic         awvld, awrdy;
    logic [7:0]   awid;
    logic [9:0]   awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic         wvld, wrdy;
    logic [63:0]  wdata;
    logic [7:0]   wstrb;
    logic         wlast;
    logic         bvld;
    logic [1:0]   bresp;
    logic         brdy, done, done_err;
    logic [15:0]  done_fail_map;
`ifdef STORE_ENG_TAIL_STRB_EN
    logic [2:0]   cmd_tail_bytes = 3'd0;
`endif

    int checks   = 0;
    int failures = 0;

    axi_store_engine dut (
        .clk(clk), .rst_n(rst_n), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_awid(cmd_awid),
        .cmd_awaddr(cmd_awaddr), .cmd_awlen(cmd_awlen), .cmd_chunk_num(cmd_chunk_num),
        .cmd_sram_addr(cmd_sram_addr),
`ifdef STORE_ENG_TAIL_STRB_EN
        .cmd_tail_bytes(cmd_tail_bytes),
`endif
        .sram_ren(sram_ren), .sram_addr(sram_addr), .sram_rdata(sram_rdata),
        .awvld(awvld), .awrdy(awrdy), .awid(awid), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awburst(awburst), .wvld(wvld), .wrdy(wrdy), .wdata(wdata),
        .wstrb(wstrb), .wlast(wlast), .bvld(bvld), .bresp(bresp), .brdy(brdy),
        .done(done), .done_err(done_err), .done_fail_map(done_fail_map)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  awaddr;
        logic [7:0]  awlen;
        logic [3:0]  cnum;
        logic [7:0]  sram;
        int          mode;     // 0 all OKAY, 1 chunk 1 SLVERR once, 2 chunk 0 always DECERR
        bit          stall;
        int          nretry;   // resent bursts after the first pass
        int          rchunk;   // chunk index of every resent burst
        bit          exp_err;
        logic [15:0] exp_map;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] word_of(input logic [7:0] a, input logic h);
        return {24'h5A5A5A, a, 31'h0, h};
    endfunction

    function automatic logic [127:0] line_of(input logic [7:0] a);
        return {word_of(a, 1'b1), word_of(a, 1'b0)};
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_rdy"}, cmd_rdy, 1'b1);
        chk({tag, "_ctl"}, {awvld, wvld, wlast, sram_ren, brdy, done, done_err}, 7'd0);
        chk({tag, "_pay"}, {awid, awaddr, awlen, sram_addr, wstrb, wdata}, 98'd0);
        chk({tag, "_map"}, done_fail_map, 16'd0);
    endtask

    task automatic run_vec(input vec_t v, input int vi, input int abort_beat);
        int exp_aw, aw_idx, cur_k, beat_j, reads, beats_total, cycle, first_w, done_cnt;
        int attempts[16];
        bit aw_acc, pending_b, prev_ren, aw_st, w_st, done_prev, finished;
        logic [7:0]  prev_raddr, ls;
        logic [1:0]  cur_resp;
        logic [25:0] aw_hold;
        logic [72:0] w_hold;
        logic        got_err;
        logic [15:0] got_map;
        logic [9:0]  ea;
        string       p;
        p = $sformatf("v%0d", vi);
        exp_aw = int'(v.cnum) + 1 + v.nretry;
        aw_idx = 0; cur_k = 0; beat_j = 0; reads = 0; beats_total = 0; done_cnt = 0; first_w = -1;
        aw_acc = 0; pending_b = 0; prev_ren = 0; aw_st = 0; w_st = 0; done_prev = 0; finished = 0;
        prev_raddr = '0; cur_resp = 2'b00; aw_hold = '0; w_hold = '0; got_err = 0; got_map = '0;
        foreach (attempts[i]) attempts[i] = 0;

        @(negedge clk);
        chk({p, "_cmd_rdy_idle"}, cmd_rdy, 1'b1);
        cmd_awid = 8'(8'hA0 + vi); cmd_awaddr = v.awaddr; cmd_awlen = v.awlen;
        cmd_chunk_num = v.cnum; cmd_sram_addr = v.sram; cmd_vld = 1'b1;
        @(negedge clk);
        cmd_vld = 1'b0;
        cycle = 1;
        while (!finished && cycle < 3000) begin
            sram_rdata = prev_ren ? line_of(prev_raddr) : {128{1'b1}};
            prev_ren = sram_ren;
            prev_raddr = sram_addr;
            if (sram_ren) begin
                ls = 8'(int'(v.sram) + cur_k * ((int'(v.awlen) + 2) / 2) + reads);
                chk({p, "_sram_addr"}, sram_addr, ls);
                chk({p, "_rd_after_aw"}, aw_acc, 1'b1);
                reads++;
            end
            awrdy = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
            wrdy  = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
            bvld  = pending_b && (v.stall ? 1'($urandom_range(0, 1)) : 1'b1);
            bresp = bvld ? cur_resp : 2'b00;
            if (abort_beat >= 0 && wvld && beats_total == abort_beat) begin
                #2 rst_n = 1'b0;
                #1 check_reset_outputs({p, "_async_rst"});
                @(negedge clk);
                awrdy = 1'b0; wrdy = 1'b0; bvld = 1'b0; bresp = 2'b00; rst_n = 1'b1;
                return;
            end
            if (aw_st) chk({p, "_aw_hold"}, {awvld, awid, awaddr, awlen}, {1'b1, aw_hold});
            if (awvld) begin
                if (!awrdy) begin
                    aw_hold = {awid, awaddr, awlen};
                    aw_st = 1;
                end else if (aw_idx >= exp_aw) begin
                    checks++; failures++; aw_st = 0;
                    $display("FAIL %s_aw_extra actual=%0d expected=%0d", p, aw_idx + 1, exp_aw);
                end else begin
                    aw_st = 0;
                    cur_k = (aw_idx <= int'(v.cnum)) ? aw_idx : v.rchunk;
                    ea = 10'(int'(v.awaddr) + cur_k * (int'(v.awlen) + 1) * 8);
                    chk({p, "_awaddr"}, awaddr, ea);
                    chk({p, "_aw_fixed"}, {awid, awlen, awsize, awburst},
                        {8'(8'hA0 + vi), v.awlen, 3'd3, 2'b01});
                    if (v.mode == 1) cur_resp = (cur_k == 1 && attempts[1] == 0) ? 2'b10 : 2'b00;
                    else if (v.mode == 2) cur_resp = (cur_k == 0) ? 2'b11 : 2'b00;
                    else cur_resp = 2'b00;
                    attempts[cur_k]++;
                    aw_idx++; beat_j = 0; reads = 0; aw_acc = 1;
                end
            end
            if (w_st) chk({p, "_w_hold"}, {wvld, wdata, wstrb, wlast}, {1'b1, w_hold});
            if (wvld) begin
                if (first_w < 0) first_w = cycle;
                if (!wrdy) begin
                    w_hold = {wdata, wstrb, wlast};
                    w_st = 1;
                end else begin
                    w_st = 0;
                    ls = 8'(int'(v.sram) + cur_k * ((int'(v.awlen) + 2) / 2) + beat_j / 2);
                    chk({p, "_w_after_aw"}, aw_acc, 1'b1);
                    chk({p, "_wdata"}, wdata, word_of(ls, 1'(beat_j % 2)));
                    chk({p, "_wlast_strb"}, {wlast, wstrb}, {(beat_j == int'(v.awlen)), 8'hFF});
                    if (wlast) begin
                        pending_b = 1;
                        aw_acc = 0;
                    end
                    beat_j++;
                    beats_total++;
                end
            end
            if (bvld && brdy) pending_b = 0;
            if (done_prev) begin
                chk({p, "_done_one_cycle"}, {done, cmd_rdy}, 2'b01);
                chk({p, "_map_held"}, done_fail_map, got_map);
                finished = 1;
            end else if (done) begin
                done_cnt++;
                got_err = done_err;
                got_map = done_fail_map;
                done_prev = 1;
            end
            @(negedge clk);
            cycle++;
        end
        if (!finished) begin
            checks++; failures++;
            $display("FAIL %s_timeout actual=%0d cycles expected=done", p, cycle);
        end
        chk({p, "_aw_count"}, aw_idx, exp_aw);
        chk({p, "_beats"}, beats_total, exp_aw * (int'(v.awlen) + 1));
        chk({p, "_done_cnt"}, done_cnt, 1);
        chk({p, "_done_err"}, got_err, v.exp_err);
        chk({p, "_fail_map"}, got_map, v.exp_map);
        if (!v.stall) chk({p, "_latency"}, first_w, 4);
    endtask

    initial begin
        vecs[0] = '{10'h040, 8'd3, 4'd1,  8'h10, 0, 1'b0, 0, 0, 1'b0, 16'h0000};
        vecs[1] = '{10'h040, 8'd3, 4'd1,  8'h10, 1, 1'b0, 1, 1, 1'b0, 16'h0000};
        vecs[2] = '{10'h040, 8'd3, 4'd1,  8'h10, 2, 1'b0, 3, 0, 1'b1, 16'h0001};
        vecs[3] = '{10'h3F0, 8'd2, 4'd1,  8'hFE, 0, 1'b1, 0, 0, 1'b0, 16'h0000};
        vecs[4] = '{10'h008, 8'd0, 4'd0,  8'h33, 0, 1'b0, 0, 0, 1'b0, 16'h0000};
        vecs[5] = '{10'h000, 8'd0, 4'd15, 8'h00, 0, 1'b0, 0, 0, 1'b0, 16'h0000};

        rst_n = 1'b0; cmd_vld = 1'b0; cmd_awid = '0; cmd_awaddr = '0; cmd_awlen = '0;
        cmd_chunk_num = '0; cmd_sram_addr = '0; sram_rdata = '0; awrdy = 1'b0; wrdy = 1'b0;
        bvld = 1'b0; bresp = 2'b00;
        #2 check_reset_outputs("por");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int vi = 0; vi < 6; vi++) run_vec(vecs[vi], vi, -1);
        run_vec(vecs[0], 10, 1);
        run_vec(vecs[0], 11, -1);
        run_vec(vecs[3], 12, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
